// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-way light sequencer with 1 s prescaler and one shared bin-to-BCD engine.
// Optional night flashing mode enabled by defining NIGHT_FLASH_EN.
module traffic_light_ctrl #(
  parameter int TICK_DIV = 100_000_000,
  parameter int T_GREEN  = 25,
  parameter int T_YELLOW = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
`ifdef NIGHT_FLASH_EN
  input  logic       night,
`endif
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [7:0] ns_bcd,
  output logic [7:0] ew_bcd,
  output logic       bcd_busy
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [6:0] C_G  = 7'(T_GREEN);
  localparam logic [6:0] C_Y  = 7'(T_YELLOW);
  localparam logic [6:0] C_GY = 7'(T_GREEN + T_YELLOW);
  localparam logic [2:0] L_R = 3'b100;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_G = 3'b001;

  typedef enum logic [2:0] {
    NS_G, NS_Y, EW_G, EW_Y
`ifdef NIGHT_FLASH_EN
    , FLASH
`endif
  } ph_e;

  typedef enum logic [1:0] {
    C_IDLE, C_LOAD, C_SHIFT, C_STORE
  } cst_e;

  logic [PW-1:0] presc_q, presc_d;
  ph_e           ph_q, ph_d;
  logic [6:0]    ns_cnt_q, ns_cnt_d;
  logic [6:0]    ew_cnt_q, ew_cnt_d;
  logic [2:0]    ns_light_q, ns_light_d;
  logic [2:0]    ew_light_q, ew_light_d;
  cst_e          cst_q, cst_d;
  logic          pend_q, pend_d;
  logic          ch_q, ch_d;
  logic [2:0]    step_q, step_d;
  logic [15:0]   sr_q, sr_d;
  logic [7:0]    ns_bcd_q, ns_bcd_d;
  logic [7:0]    ew_bcd_q, ew_bcd_d;
  logic          tick;
  logic [6:0]    act;
  logic [15:0]   adj;

  assign tick = en && (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    presc_d = presc_q;
    if (en) presc_d = tick ? '0 : presc_q + PW'(1);
  end

  always_comb begin
    ph_d     = ph_q;
    ns_cnt_d = ns_cnt_q;
    ew_cnt_d = ew_cnt_q;
    act = (ph_q == NS_G || ph_q == NS_Y) ? ns_cnt_q : ew_cnt_q;
    if (tick) begin
      if (act == 7'd1) begin
        case (ph_q)
          NS_G: begin
            ph_d = NS_Y; ns_cnt_d = C_Y; ew_cnt_d = C_Y;
          end
          NS_Y: begin
            ph_d = EW_G; ns_cnt_d = C_GY; ew_cnt_d = C_G;
          end
          EW_G: begin
            ph_d = EW_Y; ns_cnt_d = C_Y; ew_cnt_d = C_Y;
          end
          EW_Y: begin
            ph_d = NS_G; ns_cnt_d = C_G; ew_cnt_d = C_GY;
          end
          default: ;
        endcase
      end else begin
        ns_cnt_d = ns_cnt_q - 7'd1;
        ew_cnt_d = ew_cnt_q - 7'd1;
      end
    end
`ifdef NIGHT_FLASH_EN
    // Night handling overrides the normal sequence on any tick
    if (tick && night) begin
      ph_d = FLASH; ns_cnt_d = '0; ew_cnt_d = '0;
    end else if (tick && ph_q == FLASH) begin
      ph_d = NS_G; ns_cnt_d = C_G; ew_cnt_d = C_GY;
    end
`endif
  end

  always_comb begin
    ns_light_d = L_G;
    ew_light_d = L_R;
    case (ph_d)
      NS_Y: ns_light_d = L_Y;
      EW_G: begin
        ns_light_d = L_R; ew_light_d = L_G;
      end
      EW_Y: begin
        ns_light_d = L_R; ew_light_d = L_Y;
      end
`ifdef NIGHT_FLASH_EN
      FLASH: begin
        if (ph_q != FLASH) ns_light_d = L_Y;
        else if (tick) ns_light_d = {1'b0, ~ns_light_q[1], 1'b0};
        else ns_light_d = ns_light_q;
        ew_light_d = ns_light_d;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    cst_d    = cst_q;
    pend_d   = pend_q | tick;
    ch_d     = ch_q;
    step_d   = step_q;
    sr_d     = sr_q;
    ns_bcd_d = ns_bcd_q;
    ew_bcd_d = ew_bcd_q;
    adj      = sr_q;
    if (adj[15:12] > 4'd4) adj[15:12] = adj[15:12] + 4'd3;
    if (adj[11:8] > 4'd4) adj[11:8] = adj[11:8] + 4'd3;
    case (cst_q)
      C_IDLE: begin
        if (pend_q || tick) begin
          cst_d = C_LOAD; pend_d = 1'b0; ch_d = 1'b0;
        end
      end
      C_LOAD: begin
        sr_d   = {8'h00, 1'b0, ch_q ? ew_cnt_q : ns_cnt_q};
        step_d = '0;
        cst_d  = C_SHIFT;
      end
      C_SHIFT: begin
        sr_d   = adj << 1;
        step_d = step_q + 3'd1;
        if (step_q == 3'd7) cst_d = C_STORE;
      end
      C_STORE: begin
        if (!ch_q) begin
          ns_bcd_d = sr_q[15:8]; ch_d = 1'b1; cst_d = C_LOAD;
        end else begin
          ew_bcd_d = sr_q[15:8]; ch_d = 1'b0; cst_d = C_IDLE;
        end
      end
      default: cst_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q    <= '0;
      ph_q       <= NS_G;
      ns_cnt_q   <= C_G;
      ew_cnt_q   <= C_GY;
      ns_light_q <= L_G;
      ew_light_q <= L_R;
      cst_q      <= C_IDLE;
      pend_q     <= 1'b1;
      ch_q       <= 1'b0;
      step_q     <= '0;
      sr_q       <= '0;
      ns_bcd_q   <= '0;
      ew_bcd_q   <= '0;
    end else begin
      presc_q    <= presc_d;
      ph_q       <= ph_d;
      ns_cnt_q   <= ns_cnt_d;
      ew_cnt_q   <= ew_cnt_d;
      ns_light_q <= ns_light_d;
      ew_light_q <= ew_light_d;
      cst_q      <= cst_d;
      pend_q     <= pend_d;
      ch_q       <= ch_d;
      step_q     <= step_d;
      sr_q       <= sr_d;
      ns_bcd_q   <= ns_bcd_d;
      ew_bcd_q   <= ew_bcd_d;
    end
  end

  assign ns_light = ns_light_q;
  assign ew_light = ew_light_q;
  assign ns_bcd   = ns_bcd_q;
  assign ew_bcd   = ew_bcd_q;
  assign bcd_busy = (cst_q != C_IDLE);

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: directed checks of the light sequencer and BCD engine.
// Night-flash checks run only when NIGHT_FLASH_EN is defined.
module tb_traffic_light_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, rst_b_n;
`ifdef NIGHT_FLASH_EN
  logic       night;
`endif
  logic [2:0] ns_light, ew_light, b_ns_light, b_ew_light;
  logic [7:0] ns_bcd, ew_bcd, b_ns_bcd, b_ew_bcd;
  logic       bcd_busy, b_busy;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  traffic_light_ctrl #(
    .TICK_DIV(32), .T_GREEN(3), .T_YELLOW(2)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en),
`ifdef NIGHT_FLASH_EN
    .night(night),
`endif
    .ns_light(ns_light), .ew_light(ew_light),
    .ns_bcd(ns_bcd), .ew_bcd(ew_bcd), .bcd_busy(bcd_busy)
  );

  traffic_light_ctrl #(
    .TICK_DIV(24), .T_GREEN(87), .T_YELLOW(12)
  ) u_big (
    .clk(clk), .rst_n(rst_b_n), .en(1'b1),
`ifdef NIGHT_FLASH_EN
    .night(1'b0),
`endif
    .ns_light(b_ns_light), .ew_light(b_ew_light),
    .ns_bcd(b_ns_bcd), .ew_bcd(b_ew_bcd), .bcd_busy(b_busy)
  );

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic reset_a();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    cyc = 0;
  endtask

  function automatic logic [7:0] ns_l(input int p);
    return (p == 0) ? 8'h01 : (p == 1) ? 8'h02 : 8'h04;
  endfunction

  function automatic logic [7:0] ew_l(input int p);
    return (p == 2) ? 8'h01 : (p == 3) ? 8'h02 : 8'h04;
  endfunction

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction

  int t2_ph[11] = '{0, 0, 0, 1, 1, 2, 2, 2, 3, 3, 0};
  int t2_ns[11] = '{3, 2, 1, 2, 1, 5, 4, 3, 2, 1, 3};
  int t2_ew[11] = '{5, 4, 3, 2, 1, 3, 2, 1, 2, 1, 5};

  initial begin
    int t, ph, mns, mew, act;
    rst_n = 1'b0;
    rst_b_n = 1'b0;
    en = 1'b1;
`ifdef NIGHT_FLASH_EN
    night = 1'b0;
`endif
    @(negedge clk);
    reset_a();

    // reset release and first conversion pair
    check("rst_ns_light", 8'(ns_light), 8'h01);
    check("rst_ew_light", 8'(ew_light), 8'h04);
    check("rst_busy", 8'(bcd_busy), 8'h00);
    for (int c = 1; c <= 21; c++) begin
      goto(c);
      check("t1_busy", 8'(bcd_busy), (c <= 20) ? 8'h01 : 8'h00);
      check("t1_ns_bcd", ns_bcd, (c >= 11) ? 8'h03 : 8'h00);
      check("t1_ew_bcd", ew_bcd, (c >= 21) ? 8'h05 : 8'h00);
    end

    // ten ticks through the full cycle
    for (int k = 1; k <= 10; k++) begin
      t = 31 + 32 * (k - 1);
      goto(t);
      check("t2_ns_pre", 8'(ns_light), ns_l(t2_ph[k-1]));
      check("t2_ew_pre", 8'(ew_light), ew_l(t2_ph[k-1]));
      goto(t + 1);
      check("t2_ns_light", 8'(ns_light), ns_l(t2_ph[k]));
      check("t2_ew_light", 8'(ew_light), ew_l(t2_ph[k]));
      goto(t + 21);
      check("t2_ns_bcd", ns_bcd, bcd(t2_ns[k]));
      check("t2_ew_bcd", ew_bcd, bcd(t2_ew[k]));
    end

    // stall 100 cycles in NS_Y
    goto(416);
    check("t4_ns_y", 8'(ns_light), 8'h02);
    goto(430);
    en = 1'b0;
    goto(448);
    check("t4_no_tick", 8'(bcd_busy), 8'h00);
    goto(500);
    check("t4_ns_hold", 8'(ns_light), 8'h02);
    check("t4_ew_hold", 8'(ew_light), 8'h04);
    check("t4_nsb_hold", ns_bcd, 8'h02);
    check("t4_ewb_hold", ew_bcd, 8'h02);
    goto(530);
    en = 1'b1;
    goto(547);
    check("t4_pre_busy", 8'(bcd_busy), 8'h00);
    goto(548);
    check("t4_tick_busy", 8'(bcd_busy), 8'h01);
    check("t4_ns_still_y", 8'(ns_light), 8'h02);
    goto(558);
    check("t4_ns_bcd", ns_bcd, 8'h01);
    goto(567);
    check("t4_ew_old", ew_bcd, 8'h02);
    goto(568);
    check("t4_ew_bcd", ew_bcd, 8'h01);

    // reset in the middle of a conversion
    goto(580);
    check("t5_ns_r", 8'(ns_light), 8'h04);
    check("t5_ew_g", 8'(ew_light), 8'h01);
    goto(584);
    check("t5_busy_mid", 8'(bcd_busy), 8'h01);
    rst_n = 1'b0;
    step();
    check("t5_ns_light", 8'(ns_light), 8'h01);
    check("t5_ew_light", 8'(ew_light), 8'h04);
    check("t5_ns_bcd", ns_bcd, 8'h00);
    check("t5_ew_bcd", ew_bcd, 8'h00);
    check("t5_busy", 8'(bcd_busy), 8'h00);
    step();
    step();
    rst_n = 1'b1;
    cyc = 0;
    goto(10);
    check("t5_no_stale", ns_bcd, 8'h00);
    goto(11);
    check("t5_ns_new", ns_bcd, 8'h03);
    goto(21);
    check("t5_ew_new", ew_bcd, 8'h05);
    goto(31);
    check("t5_tick_idle", 8'(bcd_busy), 8'h00);
    goto(32);
    check("t5_tick_busy", 8'(bcd_busy), 8'h01);

    // large durations: every count 1..99 through the converter
    rst_b_n = 1'b1;
    cyc = 0;
    goto(10);
    check("t3_ns_early", b_ns_bcd, 8'h00);
    goto(11);
    check("t3_ns_87", b_ns_bcd, 8'h87);
    goto(20);
    check("t3_ew_early", b_ew_bcd, 8'h00);
    goto(21);
    check("t3_ew_99", b_ew_bcd, 8'h99);
    ph = 0;
    mns = 87;
    mew = 99;
    for (int k = 1; k <= 198; k++) begin
      t = 23 + 24 * (k - 1);
      act = (ph < 2) ? mns : mew;
      if (act == 1) begin
        ph = (ph + 1) % 4;
        case (ph)
          0: begin mns = 87; mew = 99; end
          1: begin mns = 12; mew = 12; end
          2: begin mns = 99; mew = 87; end
          default: begin mns = 12; mew = 12; end
        endcase
      end else begin
        mns--;
        mew--;
      end
      goto(t + 1);
      check("t3_ns_light", 8'(b_ns_light), ns_l(ph));
      check("t3_ew_light", 8'(b_ew_light), ew_l(ph));
      goto(t + 21);
      check("t3_ns_bcd", b_ns_bcd, bcd(mns));
      check("t3_ew_bcd", b_ew_bcd, bcd(mew));
    end

`ifdef NIGHT_FLASH_EN
    night = 1'b1;
    reset_a();
    goto(31);
    check("t6_pre_ns", 8'(ns_light), 8'h01);
    goto(32);
    check("t6_ns_y1", 8'(ns_light), 8'h02);
    check("t6_ew_y1", 8'(ew_light), 8'h02);
    goto(52);
    check("t6_ns_bcd0", ns_bcd, 8'h00);
    check("t6_ew_bcd0", ew_bcd, 8'h00);
    goto(63);
    check("t6_hold_y", 8'(ns_light), 8'h02);
    goto(64);
    check("t6_ns_off", 8'(ns_light), 8'h00);
    check("t6_ew_off", 8'(ew_light), 8'h00);
    goto(96);
    check("t6_ns_y2", 8'(ns_light), 8'h02);
    check("t6_ew_y2", 8'(ew_light), 8'h02);
    goto(100);
    night = 1'b0;
    goto(128);
    check("t6_exit_ns", 8'(ns_light), 8'h01);
    check("t6_exit_ew", 8'(ew_light), 8'h04);
    goto(148);
    check("t6_exit_nsb", ns_bcd, 8'h03);
    check("t6_exit_ewb", ew_bcd, 8'h05);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
